// File: rtl/nicnac_fetch_unit_pkg.sv
// Shared NICNAC16 types for the fetch stage: widths, word/address types,
// fetch FSM states and the prefetch queue entry.
package nicnac16_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    RUN,
    HALT_DRAIN,
    HALTED_ST
  } fetch_state_e;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  // PC arithmetic wraps modulo 2^ADDR_W with no carry out.
  function automatic addr_t nextPc(input addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/nicnac_fetch_unit_if.sv
// ROM, decode, redirect and halt signals of the fetch stage.
// Perf counter signals exist only when NICNAC_FETCH_PERF_EN is defined.
interface nicnac_fetch_unit_if;
  import nicnac16_pkg::*;

  addr_t  romAddress;
  instr_t romValue;
  logic   instrValid;
  instr_t instr;
  addr_t  instrPc;
  logic   instrReady;
  logic   redirectValid;
  addr_t  redirectAddr;
  logic   halt;
  logic   halted;
`ifdef NICNAC_FETCH_PERF_EN
  logic [15:0] fetchCount;
  logic [7:0]  flushCount;

  modport master (
    output romAddress, instrValid, instr, instrPc, halted, fetchCount, flushCount,
    input  romValue, instrReady, redirectValid, redirectAddr, halt
  );
  modport slave (
    input  romAddress, instrValid, instr, instrPc, halted, fetchCount, flushCount,
    output romValue, instrReady, redirectValid, redirectAddr, halt
  );
`else
  modport master (
    output romAddress, instrValid, instr, instrPc, halted,
    input  romValue, instrReady, redirectValid, redirectAddr, halt
  );
  modport slave (
    input  romAddress, instrValid, instr, instrPc, halted,
    output romValue, instrReady, redirectValid, redirectAddr, halt
  );
`endif
endinterface

// File: rtl/nicnac_fetch_unit_queue.sv
// Small synchronous FIFO of fetch entries with push/pop/flush; flush wins
// over push. Also intended for reuse as the data-side buffer.
module nicnac_fetch_queue
  import nicnac16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_pushEntry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] r_wrPtr;
  logic [PTR_W:0] r_rdPtr;
  fetch_entry_t   r_mem [DEPTH];
  logic           w_doPush;
  logic           w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                    (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign o_head   = r_mem[r_rdPtr[PTR_W-1:0]];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr[PTR_W-1:0]] <= i_pushEntry;
        r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/nicnac_fetch_unit.sv
// NICNAC16 instruction fetch stage: PC, prefetch queue, redirect and halt.
// Optional perf counters are enabled by defining NICNAC_FETCH_PERF_EN.
module nicnac_fetch_unit
  import nicnac16_pkg::*;
#(
  parameter int    QUEUE_DEPTH  = 2,
  parameter addr_t RESET_VECTOR = 8'h00
) (
  input logic clk,
  input logic rst_n,
  nicnac_fetch_unit_if.master io_fetch
);

  fetch_state_e r_state;
  addr_t        r_pc;
  logic         r_halted;
  fetch_entry_t r_lastHead;
  fetch_entry_t w_head;
  fetch_entry_t w_pushEntry;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  logic         w_redirect;

  assign w_redirect  = io_fetch.redirectValid;
  assign w_pop       = !w_empty && io_fetch.instrReady;
  assign w_push      = (r_state == RUN) && !io_fetch.halt && !w_redirect && (!w_full || w_pop);
  assign w_pushEntry = '{instr: io_fetch.romValue, pc: r_pc};

  nicnac_fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pushEntry(w_pushEntry),
    .i_pop      (w_pop),
    .i_flush    (w_redirect),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pc <= RESET_VECTOR;
    else if (w_redirect) r_pc <= io_fetch.redirectAddr;
    else if (w_push)     r_pc <= nextPc(r_pc);
  end

  // Drain is judged on the current occupancy, so HALTED asserts one edge after the last pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: if (io_fetch.halt) r_state <= HALT_DRAIN;
        HALT_DRAIN: begin
          if (!io_fetch.halt) begin
            r_state <= RUN;
          end else if (w_empty) begin
            r_state  <= HALTED_ST;
            r_halted <= 1'b1;
          end
        end
        HALTED_ST: begin
          if (!io_fetch.halt) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Keeps INSTR/INSTR_PC at the last head while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lastHead <= '0;
    else if (!w_empty) r_lastHead <= w_head;
  end

  assign io_fetch.romAddress = r_pc;
  assign io_fetch.instrValid = !w_empty;
  assign io_fetch.instr      = w_empty ? r_lastHead.instr : w_head.instr;
  assign io_fetch.instrPc    = w_empty ? r_lastHead.pc    : w_head.pc;
  assign io_fetch.halted     = r_halted;

`ifdef NICNAC_FETCH_PERF_EN
  logic [15:0] r_fetchCount;
  logic [7:0]  r_flushCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_push && (r_fetchCount != 16'hFFFF)) r_fetchCount <= r_fetchCount + 16'd1;
      if (w_redirect) r_flushCount <= r_flushCount + 8'd1;
    end
  end

  assign io_fetch.fetchCount = r_fetchCount;
  assign io_fetch.flushCount = r_flushCount;
`endif

endmodule
